leaf_stream_fifo: RTL and testbench



---
 rtl/leaf_stream_pkg.sv | 8 +
 rtl/leaf_stream_mem.sv | 26 ++
 rtl/leaf_stream_fifo.sv | 95 +++++++++
 tb/tb_leaf_stream_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/leaf_stream_pkg.sv
// Shared types for the leaf stream FIFO: sequence tag width and type.
package leaf_stream_pkg;

  localparam int SEQ_W = 8;

  typedef logic [SEQ_W-1:0] seq_t;

endpackage

// File: rtl/leaf_stream_mem.sv
// Storage array for the leaf FIFO: one write port, asynchronous read, no reset.
// Zero read latency so the head entry falls straight through to the outputs.
module leaf_stream_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/leaf_stream_fifo.sv
// First-word-fall-through FIFO with a wrapping per-word sequence tag; one cycle input to output.
// in_ready depends only on occupancy, rst_n and flush, never on out_ready, so a full FIFO stalls a cycle.
module leaf_stream_fifo
  import leaf_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [CW-1:0]     count
);

  localparam int ENTRY_W = DATA_W + SEQ_W;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  seq_t               seq_q, seq_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign in_ready  = rst_n && !flush && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  // A pop presented alongside flush or reset is dropped, not half-applied.
  assign pop       = out_valid && out_ready && rst_n && !flush;

  assign wr_entry            = {in_data, seq_q};
  assign {out_data, out_seq} = rd_entry;
  assign count               = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    if (flush) begin
      // The tag keeps running across a flush so downstream can spot the gap.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        seq_d    = seq_q + seq_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
    end
  end

  leaf_stream_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Self-checking bench: directed vector table, then streaming and random traffic against a queue model.
module tb_leaf_stream_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data, out_seq;
  logic [2:0] count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  leaf_stream_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .count     (count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of {data, seq} words plus a free-running tag.
  typedef struct packed { logic [7:0] d; logic [7:0] s; } word_t;
  word_t m_q[$];
  int    m_seq = 0;
  int    s_ov, s_d, s_s, s_cnt;

  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [7:0] d, input logic ordy);
    logic exp_ir, do_push, do_pop;
    rst_n = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ir = r && !f && (m_q.size() < DEPTH);
    s_ov = int'(out_valid); s_d = int'(out_data); s_s = int'(out_seq); s_cnt = int'(count);
    chk("in_ready", int'(in_ready), int'(exp_ir));
    chk("out_valid", s_ov, int'(m_q.size() != 0));
    chk("count", s_cnt, m_q.size());
    if (m_q.size() != 0) begin
      chk("out_data", s_d, int'(m_q[0].d));
      chk("out_seq", s_s, int'(m_q[0].s));
    end
    @(posedge clk);
    if (!r) begin
      m_q.delete();
      m_seq = 0;
    end else if (f) begin
      m_q.delete();
    end else begin
      do_pop  = (m_q.size() != 0) && ordy;
      do_push = iv && exp_ir;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back('{d: d, s: 8'(m_seq)});
        m_seq = (m_seq + 1) % 256;
      end
    end
    #1;
  endtask

  typedef struct {
    logic       r, f, iv;
    logic [7:0] d;
    logic       ordy;
    logic       chk_st;
    logic       e_ir, e_ov;
    int         e_cnt;
    logic [7:0] e_d, e_s;
  } vec_t;

  vec_t vec[24];

  initial begin
    int wraps, prev_s, stall_prev, prev_d, prev_sq;
    logic iv, ordy, fl;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //          r  f  iv  d      ordy chk ir ov cnt data   seq
    vec[0]  = '{0, 0, 0, 8'h00, 0,   0,  0, 0, 0, 8'h00, 8'd0};
    vec[1]  = '{1, 0, 1, 8'h11, 0,   1,  1, 0, 0, 8'h00, 8'd0};
    vec[2]  = '{1, 0, 1, 8'h22, 0,   1,  1, 1, 1, 8'h11, 8'd0};
    vec[3]  = '{1, 0, 1, 8'h33, 0,   1,  1, 1, 2, 8'h11, 8'd0};
    vec[4]  = '{1, 0, 0, 8'h00, 0,   1,  1, 1, 3, 8'h11, 8'd0};
    vec[5]  = '{1, 0, 0, 8'h00, 1,   1,  1, 1, 3, 8'h11, 8'd0};
    vec[6]  = '{1, 0, 0, 8'h00, 1,   1,  1, 1, 2, 8'h22, 8'd1};
    vec[7]  = '{1, 0, 0, 8'h00, 1,   1,  1, 1, 1, 8'h33, 8'd2};
    vec[8]  = '{1, 0, 0, 8'h00, 1,   1,  1, 0, 0, 8'h00, 8'd0};
    vec[9]  = '{1, 0, 1, 8'hA0, 0,   1,  1, 0, 0, 8'h00, 8'd0};
    vec[10] = '{1, 0, 1, 8'hA1, 0,   1,  1, 1, 1, 8'hA0, 8'd3};
    vec[11] = '{1, 0, 1, 8'hA2, 0,   1,  1, 1, 2, 8'hA0, 8'd3};
    vec[12] = '{1, 0, 1, 8'hA3, 0,   1,  1, 1, 3, 8'hA0, 8'd3};
    vec[13] = '{1, 0, 1, 8'hA4, 0,   1,  0, 1, 4, 8'hA0, 8'd3};
    vec[14] = '{1, 0, 1, 8'hA4, 1,   1,  0, 1, 4, 8'hA0, 8'd3};
    vec[15] = '{1, 0, 0, 8'h00, 0,   1,  1, 1, 3, 8'hA1, 8'd4};
    vec[16] = '{1, 0, 0, 8'h00, 1,   1,  1, 1, 3, 8'hA1, 8'd4};
    vec[17] = '{1, 1, 0, 8'h00, 1,   1,  0, 1, 2, 8'hA2, 8'd5};
    vec[18] = '{1, 0, 1, 8'h55, 0,   1,  1, 0, 0, 8'h00, 8'd0};
    vec[19] = '{1, 0, 0, 8'h00, 0,   1,  1, 1, 1, 8'h55, 8'd7};
    vec[20] = '{1, 0, 1, 8'h66, 0,   1,  1, 1, 1, 8'h55, 8'd7};
    vec[21] = '{0, 0, 1, 8'h77, 1,   1,  0, 1, 2, 8'h55, 8'd7};
    vec[22] = '{1, 0, 1, 8'h88, 0,   1,  1, 0, 0, 8'h00, 8'd0};
    vec[23] = '{1, 0, 0, 8'h00, 0,   1,  1, 1, 1, 8'h88, 8'd0};

    for (int i = 0; i < 24; i++) begin
      rst_n = vec[i].r; flush = vec[i].f; in_valid = vec[i].iv;
      in_data = vec[i].d; out_ready = vec[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vec[i].e_ir));
      if (vec[i].chk_st) begin
        chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vec[i].e_ov));
        chk($sformatf("vec%0d_count", i), int'(count), vec[i].e_cnt);
        if (vec[i].e_ov) begin
          chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vec[i].e_d));
          chk($sformatf("vec%0d_out_seq", i), int'(out_seq), int'(vec[i].e_s));
        end
      end
      @(posedge clk);
      #1;
    end

    // Model picks up the state the table left behind: one word 0x88 tag 0.
    m_q.push_back('{d: 8'h88, s: 8'd0});
    m_seq = 1;

    // Prime two words, then stream one push and one pop per cycle.
    cycle(1, 0, 1, 8'hF0, 0);
    wraps = 0;
    prev_s = -1;
    for (int i = 0; i < 300; i++) begin
      cycle(1, 0, 1, 8'(i), 1);
      chk("stream_count", s_cnt, 2);
      if (prev_s == 255 && s_s == 0) wraps++;
      prev_s = s_s;
    end
    chk("seq_wrapped", int'(wraps >= 1), 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h00, 1);

    // Random traffic with occasional flush; stalled heads must hold steady.
    stall_prev = 0; prev_d = 0; prev_sq = 0;
    for (int i = 0; i < 10000; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 99) == 0);
      cycle(1, fl, iv, 8'($urandom), ordy);
      if (stall_prev != 0) begin
        chk("stall_data", s_d, prev_d);
        chk("stall_seq", s_s, prev_sq);
      end
      chk("count_max", int'(s_cnt <= DEPTH), 1);
      stall_prev = int'(s_ov != 0 && !ordy && !fl);
      prev_d = s_d;
      prev_sq = s_s;
    end

    // Mid-stream reset with random contents: tag restarts at zero.
    cycle(0, 0, 1, 8'h99, 1);
    cycle(1, 0, 1, 8'h42, 0);
    cycle(1, 0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
